// File: rtl/neopixel_frame_ctrl.sv
// neopixel_frame_ctrl
// Double-buffered GRB pixel store plus the frame scheduler for the NeoPixel
// serializer. The writer fills the back bank. The scheduler emits periodic
// start pulses. A committed frame becomes visible only at a start pulse, so a
// frame that is already being shifted out is never torn.
//
// state   | meaning
// S_IDLE  | refresh stopped, counter held at 0
// S_WAIT  | counting the gap up to the next start pulse
// S_START | start-pulse cycle; the swap happens here if a commit is pending
// S_HOLD  | frame in flight, no swap allowed
module neopixel_frame_ctrl #(
  parameter int NUM_PIXELS   = 8,
  parameter int FRAME_CYCLES = 10000,
  parameter int HOLD_CYCLES  = 3200
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_addr,
  input  logic [23:0] i_wr_data,
  input  logic        i_commit,
  output logic        o_commit_pending,
  output logic        o_swap,
  output logic        o_tx_start,
  input  logic [7:0]  i_tx_addr,
  output logic [23:0] o_tx_data,
  output logic        o_frame_active
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_START, S_HOLD} state_t;

  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        front_q;
  logic        pending_q;
  logic        swap_q;
  logic        start_q;
  logic        active_q;

  logic [23:0] bank0_q [NUM_PIXELS];
  logic [23:0] bank1_q [NUM_PIXELS];

  // Back-bank writes; the bank is chosen from the pre-swap front bit, so a
  // write in the swap cycle lands in the bank that is about to be shown.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        bank0_q[p] <= '0;
        bank1_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        if (i_wr_en && (i_wr_addr == 8'(p))) begin
          if (front_q) bank0_q[p] <= i_wr_data;
          else         bank1_q[p] <= i_wr_data;
        end
      end
    end
  end

  // Front-bank read port; addresses outside the pixel range read as black.
  always_comb begin
    o_tx_data = '0;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      if (i_tx_addr == 8'(p)) o_tx_data = front_q ? bank1_q[p] : bank0_q[p];
    end
  end

  // Frame scheduler, commit tracking and registered pulse outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      swap_q    <= 1'b0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      swap_q  <= 1'b0;
      if (i_commit) pending_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_q    <= '0;
          active_q <= 1'b0;
          if (i_enable) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_enable) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == FRAME_LAST) begin
            state_q  <= S_START;
            cnt_q    <= '0;
            start_q  <= 1'b1;
            active_q <= 1'b1;
            // Only a request registered before this edge swaps now; a commit
            // arriving on this same edge is kept for the next frame.
            if (pending_q) begin
              front_q   <= ~front_q;
              swap_q    <= 1'b1;
              pending_q <= i_commit;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_START: begin
          state_q <= S_HOLD;
          cnt_q   <= '0;
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            state_q  <= i_enable ? S_WAIT : S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_commit_pending = pending_q;
  assign o_swap           = swap_q;
  assign o_tx_start       = start_q;
  assign o_frame_active   = active_q;

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Testbench for neopixel_frame_ctrl with a time-schedule reference model.
`timescale 1ns/1ps
module tb_neopixel_frame_ctrl;
  localparam int N      = 8;
  localparam int F      = 200;
  localparam int H      = 64;
  localparam int PERIOD = 1 + H + F;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [7:0]  i_wr_addr = '0;
  logic [23:0] i_wr_data = '0;
  logic        i_commit = 1'b0;
  logic [7:0]  i_tx_addr = '0;
  logic        o_commit_pending, o_swap, o_tx_start, o_frame_active;
  logic [23:0] o_tx_data;

  neopixel_frame_ctrl #(.NUM_PIXELS(N), .FRAME_CYCLES(F), .HOLD_CYCLES(H)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_commit(i_commit),
    .o_commit_pending(o_commit_pending), .o_swap(o_swap), .o_tx_start(o_tx_start),
    .i_tx_addr(i_tx_addr), .o_tx_data(o_tx_data), .o_frame_active(o_frame_active)
  );

  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: banks, front select, pending, and an absolute-time
  // schedule (mode 0 = stopped, 1 = waiting for m_next_start, 2 = frame until m_frame_end).
  logic [23:0] m_bank [2][N];
  bit m_front, m_pend, m_start, m_swap, m_active;
  int m_mode, m_edge, m_next_start, m_frame_end;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) for (int p = 0; p < N; p++) m_bank[b][p] = '0;
    m_front = 0; m_pend = 0; m_start = 0; m_swap = 0; m_active = 0; m_mode = 0;
  endfunction

  function automatic void model_edge();
    bit old_front, old_pend;
    int a;
    m_edge++;
    if (i_reset) begin model_reset(); return; end
    m_start = 0; m_swap = 0;
    old_front = m_front; old_pend = m_pend;
    if (i_commit) m_pend = 1;
    case (m_mode)
      0: if (i_enable) begin m_mode = 1; m_next_start = m_edge + F; end
      1: if (!i_enable) m_mode = 0;
         else if (m_edge == m_next_start) begin
           m_mode = 2; m_frame_end = m_edge + 1 + H; m_start = 1;
           if (old_pend) begin m_swap = 1; m_front = !m_front; m_pend = i_commit; end
         end
      default: if (m_edge == m_frame_end) begin
           if (i_enable) begin m_mode = 1; m_next_start = m_edge + F; end
           else m_mode = 0;
         end
    endcase
    a = int'(i_wr_addr);
    if (i_wr_en && a < N) m_bank[!old_front][a] = i_wr_data;
    m_active = (m_mode == 2);
  endfunction

  function automatic logic [23:0] exp_data(input logic [7:0] addr);
    int a;
    a = int'(addr);
    if (a < N) return m_bank[m_front][a];
    return '0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step(); step();
    if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=0000", {o_tx_start, o_swap, o_frame_active, o_commit_pending});
    end
    n_tests++;
    for (int a = 0; a < 10; a++) begin
      i_tx_addr = 8'(a); #1;
      if (o_tx_data !== 24'h0) begin
        n_fail++; $display("FAIL reset_data addr=%0d got=%h exp=000000", a, o_tx_data);
      end
      n_tests++;
    end
    i_reset = 1'b0;
  endtask

  task automatic test_period();
    int en_edge, first, second;
    first = -1; second = -1;
    i_enable = 1'b1;
    en_edge = m_edge + 1;
    for (int c = 0; c < F + PERIOD + 5; c++) begin
      i_tx_addr = 8'($urandom_range(0, 9));
      step();
      if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== {m_start, m_swap, m_active, m_pend}) begin
        n_fail++; $display("FAIL period_ctrl edge=%0d got=%b exp=%b", m_edge,
          {o_tx_start, o_swap, o_frame_active, o_commit_pending}, {m_start, m_swap, m_active, m_pend});
      end
      n_tests++;
      if (o_tx_start === 1'b1) begin
        if (first < 0) first = m_edge; else if (second < 0) second = m_edge;
      end
    end
    if (first - en_edge != F) begin
      n_fail++; $display("FAIL first_start_delay got=%0d exp=%0d", first - en_edge, F);
    end
    n_tests++;
    if (second - first != PERIOD) begin
      n_fail++; $display("FAIL start_period got=%0d exp=%0d", second - first, PERIOD);
    end
    n_tests++;
  endtask

  task automatic test_swap();
    bit found;
    for (int i = 0; i < N; i++) begin
      i_wr_en = 1'b1; i_wr_addr = 8'(i); i_wr_data = 24'h0000FF + 24'(i);
      i_tx_addr = 8'($urandom_range(0, 9));
      step();
      if (o_tx_data !== exp_data(i_tx_addr)) begin
        n_fail++; $display("FAIL swap_prewrite_data addr=%0d got=%h exp=%h", i_tx_addr, o_tx_data, exp_data(i_tx_addr));
      end
      n_tests++;
    end
    i_wr_en = 1'b0; i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    found = 0;
    for (int c = 0; c < 2 * PERIOD; c++) begin
      step();
      if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== {m_start, m_swap, m_active, m_pend}) begin
        n_fail++; $display("FAIL swap_ctrl edge=%0d got=%b exp=%b", m_edge,
          {o_tx_start, o_swap, o_frame_active, o_commit_pending}, {m_start, m_swap, m_active, m_pend});
      end
      n_tests++;
      if (o_swap === 1'b1) begin found = 1; break; end
    end
    if (!found || o_tx_start !== 1'b1) begin
      n_fail++; $display("FAIL swap_with_start found=%0d tx_start=%b exp=1", found, o_tx_start);
    end
    n_tests++;
    i_tx_addr = 8'd3; #1;
    if (o_tx_data !== 24'h000102) begin
      n_fail++; $display("FAIL swap_read_addr3 got=%h exp=000102", o_tx_data);
    end
    n_tests++;
  endtask

  task automatic test_oob();
    bit found;
    for (int i = 0; i <= N; i++) begin
      i_wr_en = 1'b1; i_wr_addr = 8'(i);
      i_wr_data = (i == N) ? 24'hFFFFFF : 24'h0000FF + 24'(i);
      step();
    end
    i_wr_en = 1'b0; i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    found = 0;
    for (int c = 0; c < 2 * PERIOD; c++) begin
      step();
      if (o_swap === 1'b1) begin found = 1; break; end
    end
    if (!found) begin
      n_fail++; $display("FAIL oob_swap_seen got=0 exp=1");
    end
    n_tests++;
    for (int a = 0; a <= N; a++) begin
      logic [23:0] want;
      want = (a < N) ? 24'h0000FF + 24'(a) : 24'h000000;
      i_tx_addr = 8'(a); #1;
      if (o_tx_data !== want || o_tx_data !== exp_data(i_tx_addr)) begin
        n_fail++; $display("FAIL oob_read addr=%0d got=%h exp=%h", a, o_tx_data, want);
      end
      n_tests++;
    end
  endtask

  task automatic test_commit_hold();
    bit found;
    found = 0;
    for (int c = 0; c < 2 * PERIOD; c++) begin
      step();
      if (o_frame_active === 1'b1 && o_tx_start === 1'b0) begin found = 1; break; end
    end
    i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    for (int c = 0; c < 2 * PERIOD && found; c++) begin
      step();
      if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== {m_start, m_swap, m_active, m_pend}) begin
        n_fail++; $display("FAIL hold_ctrl edge=%0d got=%b exp=%b", m_edge,
          {o_tx_start, o_swap, o_frame_active, o_commit_pending}, {m_start, m_swap, m_active, m_pend});
      end
      n_tests++;
      if (o_swap === 1'b1) begin found = 0; break; end
      if (o_commit_pending !== 1'b1 || o_tx_start === 1'b1) begin
        n_fail++; $display("FAIL hold_pending pend=%b start=%b exp pend=1 start=0", o_commit_pending, o_tx_start);
      end
      n_tests++;
    end
    if (found || o_tx_start !== 1'b1) begin
      n_fail++; $display("FAIL hold_swap_at_start swapped=%0d tx_start=%b exp=1", !found, o_tx_start);
    end
    n_tests++;
  endtask

  task automatic test_commit_start();
    bit found;
    step();
    found = 0;
    for (int c = 0; c < PERIOD + 5; c++) begin
      step();
      if (o_tx_start === 1'b1) begin found = 1; break; end
    end
    if (!found || o_swap !== 1'b0) begin
      n_fail++; $display("FAIL start_noswap found=%0d swap=%b exp=0", found, o_swap);
    end
    n_tests++;
    i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    if (o_commit_pending !== 1'b1 || o_swap !== 1'b0) begin
      n_fail++; $display("FAIL start_commit_kept pend=%b swap=%b exp pend=1 swap=0", o_commit_pending, o_swap);
    end
    n_tests++;
    found = 0;
    for (int c = 0; c < PERIOD + 5; c++) begin
      step();
      if (o_tx_start === 1'b1) begin found = 1; break; end
    end
    if (!found || o_swap !== 1'b1) begin
      n_fail++; $display("FAIL start_next_swap found=%0d swap=%b exp=1", found, o_swap);
    end
    n_tests++;
  endtask

  task automatic test_enable_drop();
    int starts;
    starts = 0;
    i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    i_enable = 1'b0;
    for (int c = 0; c < F + H + 20; c++) begin
      step();
      if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== {m_start, m_swap, m_active, m_pend}) begin
        n_fail++; $display("FAIL drop_ctrl edge=%0d got=%b exp=%b", m_edge,
          {o_tx_start, o_swap, o_frame_active, o_commit_pending}, {m_start, m_swap, m_active, m_pend});
      end
      n_tests++;
      if (o_tx_start === 1'b1) starts++;
    end
    if (starts != 0 || o_commit_pending !== 1'b1 || o_frame_active !== 1'b0) begin
      n_fail++; $display("FAIL drop_final starts=%0d pend=%b active=%b exp 0/1/0", starts, o_commit_pending, o_frame_active);
    end
    n_tests++;
  endtask

  task automatic test_random();
    i_enable = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) i_enable = !i_enable;
      i_wr_en   = 1'($urandom_range(0, 1));
      i_wr_addr = 8'($urandom_range(0, 9));
      i_wr_data = 24'($urandom);
      i_commit  = ($urandom_range(0, 15) == 0);
      i_tx_addr = 8'($urandom_range(0, 9));
      step();
      if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== {m_start, m_swap, m_active, m_pend}) begin
        n_fail++; $display("FAIL rand_ctrl edge=%0d got=%b exp=%b", m_edge,
          {o_tx_start, o_swap, o_frame_active, o_commit_pending}, {m_start, m_swap, m_active, m_pend});
      end
      n_tests++;
      if (o_tx_data !== exp_data(i_tx_addr)) begin
        n_fail++; $display("FAIL rand_data edge=%0d addr=%0d got=%h exp=%h", m_edge, i_tx_addr, o_tx_data, exp_data(i_tx_addr));
      end
      n_tests++;
    end
    i_wr_en = 1'b0; i_commit = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    int starts;
    found = 0; starts = 0;
    i_enable = 1'b1;
    for (int c = 0; c < 2 * PERIOD + F; c++) begin
      step();
      if (o_frame_active === 1'b1 && o_tx_start === 1'b0) begin found = 1; break; end
    end
    for (int c = 0; c < 5; c++) step();
    if (!found || o_frame_active !== 1'b1) begin
      n_fail++; $display("FAIL midreset_in_hold found=%0d active=%b exp=1", found, o_frame_active);
    end
    n_tests++;
    #20 i_reset = 1'b1;
    #1 model_reset();
    if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_outputs got=%b exp=0000", {o_tx_start, o_swap, o_frame_active, o_commit_pending});
    end
    n_tests++;
    for (int a = 0; a < N; a++) begin
      i_tx_addr = 8'(a); #1;
      if (o_tx_data !== 24'h0) begin
        n_fail++; $display("FAIL midreset_data addr=%0d got=%h exp=000000", a, o_tx_data);
      end
      n_tests++;
    end
    i_enable = 1'b0;
    step(); step();
    i_reset = 1'b0;
    for (int c = 0; c < F + H + 20; c++) begin
      step();
      if (o_tx_start === 1'b1 || o_frame_active === 1'b1) starts++;
      if ({o_tx_start, o_swap, o_frame_active, o_commit_pending} !== {m_start, m_swap, m_active, m_pend}) begin
        n_fail++; $display("FAIL midreset_idle_ctrl edge=%0d got=%b exp=%b", m_edge,
          {o_tx_start, o_swap, o_frame_active, o_commit_pending}, {m_start, m_swap, m_active, m_pend});
      end
      n_tests++;
    end
    if (starts != 0) begin
      n_fail++; $display("FAIL midreset_no_starts got=%0d exp=0", starts);
    end
    n_tests++;
  endtask

  initial begin
    m_edge = 0; m_next_start = 0; m_frame_end = 0;
    model_reset();
    test_reset();
    test_period();
    test_swap();
    test_oob();
    test_commit_hold();
    test_commit_start();
    test_enable_drop();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
